game_sequencer: RTL
===================

Name: game_sequencer

Overview:
Top-level game-flow controller for Chip Invaders. It sequences attract, start, play, death, wave-clear and game-over phases on frame ticks. It arbitrates laser-hit and cannon-hit events into score, lives and kill commands for the alien formation. It drives enables and reset pulses consumed by the ship, laser, formation and HUD blocks.

Parameters:
INIT_LIVES, 3, lives loaded at game start (1..3)
NUM_ROWS, 3, formation rows; hit_row >= NUM_ROWS is ignored
NUM_COLUMNS, 5, formation columns; hit_col >= NUM_COLUMNS is ignored
START_FRAMES, 60, frames spent in START
DEATH_FRAMES, 90, frames spent in DYING
CLEAR_FRAMES, 60, frames spent in WAVE_CLEAR
OVER_FRAMES, 180, frames spent in GAME_OVER

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse per video frame
btn_start  in  1  debounced start/fire level
alien_hit  in  1  one-cycle pulse: laser struck alien (hit_row, hit_col)
hit_row  in  2  row of struck alien (0 = top)
hit_col  in  3  column of struck alien
cannon_hit  in  1  one-cycle pulse: alien shot struck cannon
aliens_all_dead  in  1  level: alive matrix empty
aliens_landed  in  1  level: formation reached cannon row
state  out  3  ATTRACT=0, START=1, PLAYING=2, DYING=3, WAVE_CLEAR=4, GAME_OVER=5
play_enable  out  1  high only in PLAYING
formation_reset  out  1  one-cycle pulse: reload formation
kill_valid  out  1  one-cycle pulse: clear alien kill_row/kill_col
kill_row  out  2  registered hit_row
kill_col  out  3  registered hit_col
laser_clear  out  1  one-cycle pulse: cancel in-flight laser
lives  out  2  remaining lives
score  out  8  binary score, saturating
wave  out  3  wave number, saturating at 7
hud_blink  out  1  blink phase for HUD

Behaviour:
- Reset: state=ATTRACT, lives=INIT_LIVES, score=0, wave=0, all pulses 0, kill_row/col=0, hud_blink=0, timer=0, btn_start edge register=0.
- All outputs registered.
- Frame timer: loaded with the phase's *_FRAMES on entry to START, DYING, WAVE_CLEAR or GAME_OVER. Decrements on each frame_tick. The exit transition occurs on the clock of the frame_tick that takes it from 1 to 0, so a phase lasts exactly N ticks.
- ATTRACT: rising edge of btn_start (registered edge detect) moves to START. Same cycle loads score=0, lives=INIT_LIVES, wave=0. formation_reset and laser_clear pulse in the next cycle.
- START: on timer expiry, go to PLAYING.
- PLAYING, alien_hit with in-range row/col, on the next cycle:
  - kill_valid=1 with kill_row/kill_col.
  - score += (NUM_ROWS - hit_row), saturating at 255.
  - laser_clear=1.
- PLAYING, cannon_hit: lives decrements (floor 0), laser_clear pulses, go to DYING.
- PLAYING, aliens_landed: lives forced to 0, go to DYING. aliens_landed has priority over cannon_hit; only one decrement occurs.
- PLAYING, aliens_all_dead (no death event that cycle): go to WAVE_CLEAR, laser_clear pulses.
- Simultaneous alien_hit and cannon_hit: both are honoured. The kill and score are applied, then DYING is entered.
- DYING exit: on timer expiry, if lives==0 go to GAME_OVER. Else if aliens_all_dead go to WAVE_CLEAR. Else go to PLAYING without a formation reset.
- WAVE_CLEAR exit: on timer expiry, wave += 1 (saturating at 7), formation_reset pulses, go to START.
- GAME_OVER exit: on timer expiry, go to ATTRACT. score and lives hold until the next game start.
- Events outside PLAYING: alien_hit, cannon_hit, aliens_* and btn_start are ignored, except btn_start in ATTRACT.
- hud_blink: toggles every 16 frame_ticks while in DYING or GAME_OVER. Forced 0 in all other states and on each state change.
- Reset asserted mid-phase returns to the reset values in the next cycle with no pulses emitted.

Test Plan:
- Reset, then btn_start 0→1 → state 1, formation_reset and laser_clear pulse once, lives=3, score=0. After 60 frame_ticks, state=2.
- PLAYING, alien_hit with row=0, col=4 → next cycle kill_valid=1, kill_row=0, kill_col=4, score=3. Repeat with row=2 → score=4. Row=3 → no kill_valid, score unchanged.
- PLAYING, cannon_hit and alien_hit (row=1) in the same cycle → score +2, lives 3→2, state=3. After 90 ticks, state=2. hud_blink toggles at ticks 16, 32, …
- Three cannon_hits across plays → lives=0, DYING then GAME_OVER. After 180 ticks, ATTRACT, score retained. Holding btn_start high does not restart until it is released and pressed again.
- aliens_all_dead in PLAYING → WAVE_CLEAR. After 60 ticks, wave=1, formation_reset pulses, state=START. Eight clears keep wave=7. Score preloaded at 254 plus a row-0 hit → 255.
- aliens_landed together with cannon_hit at lives=3 → lives=0 (single update), GAME_OVER after DYING. Reset asserted mid-DYING → state=0 next cycle, no pulses.

Source files
------------

// File: rtl/game_sequencer_if.sv
// game_sequencer_if: event inputs and control outputs between the Chip Invaders blocks and the game sequencer.
interface game_sequencer_if;
  logic       frame_tick;
  logic       btn_start;
  logic       alien_hit;
  logic [1:0] hit_row;
  logic [2:0] hit_col;
  logic       cannon_hit;
  logic       aliens_all_dead;
  logic       aliens_landed;
  logic [2:0] state;
  logic       play_enable;
  logic       formation_reset;
  logic       kill_valid;
  logic [1:0] kill_row;
  logic [2:0] kill_col;
  logic       laser_clear;
  logic [1:0] lives;
  logic [7:0] score;
  logic [2:0] wave;
  logic       hud_blink;
  modport master (
    output frame_tick, btn_start, alien_hit, hit_row, hit_col, cannon_hit, aliens_all_dead, aliens_landed,
    input  state, play_enable, formation_reset, kill_valid, kill_row, kill_col, laser_clear, lives, score, wave, hud_blink
  );
  modport slave (
    input  frame_tick, btn_start, alien_hit, hit_row, hit_col, cannon_hit, aliens_all_dead, aliens_landed,
    output state, play_enable, formation_reset, kill_valid, kill_row, kill_col, laser_clear, lives, score, wave, hud_blink
  );
endinterface

// File: rtl/game_sequencer.sv
// game_sequencer: Chip Invaders game-flow FSM turning hit events into score, lives, kills and block control pulses.
module game_sequencer #(
  parameter int INIT_LIVES   = 3,
  parameter int NUM_ROWS     = 3,
  parameter int NUM_COLUMNS  = 5,
  parameter int START_FRAMES = 60,
  parameter int DEATH_FRAMES = 90,
  parameter int CLEAR_FRAMES = 60,
  parameter int OVER_FRAMES  = 180
) (
  input logic              clk,
  input logic              reset,
  game_sequencer_if.slave  bus
);
  typedef enum logic [2:0] {ATTRACT, START, PLAYING, DYING, WAVE_CLEAR, GAME_OVER} state_e;
  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_load_d;
  logic [3:0]  blink_cnt_q;
  logic        btn_q, hud_q, play_q, fr_q, kv_q, lc_q;
  logic [1:0]  kill_row_q, lives_q, lives_dec_d;
  logic [2:0]  kill_col_q, wave_q, wave_inc_d;
  logic [7:0]  score_q, score_hit_d;
  logic [8:0]  score_sum_d;
  logic        btn_rise_d, expire_d, hit_ok_d, blinking_d;
  always_comb begin
    btn_rise_d   = bus.btn_start & ~btn_q;
    expire_d     = bus.frame_tick && timer_q == 16'd1;
    hit_ok_d     = bus.alien_hit && 32'(bus.hit_row) < NUM_ROWS && 32'(bus.hit_col) < NUM_COLUMNS;
    score_sum_d  = {1'b0, score_q} + 9'(NUM_ROWS - 32'(bus.hit_row));
    score_hit_d  = score_sum_d[8] ? 8'hff : score_sum_d[7:0];
    lives_dec_d  = lives_q == 2'd0 ? 2'd0 : lives_q - 2'd1;
    wave_inc_d   = wave_q == 3'd7 ? 3'd7 : wave_q + 3'd1;
    blinking_d   = state_q == DYING || state_q == GAME_OVER;
    state_d      = state_q;
    case (state_q)
      ATTRACT:    state_d = btn_rise_d ? START : ATTRACT;
      START:      state_d = expire_d ? PLAYING : START;
      PLAYING:    state_d = (bus.aliens_landed || bus.cannon_hit) ? DYING :
                            bus.aliens_all_dead ? WAVE_CLEAR : PLAYING;
      DYING:      state_d = !expire_d ? DYING : lives_q == 2'd0 ? GAME_OVER :
                            bus.aliens_all_dead ? WAVE_CLEAR : PLAYING;
      WAVE_CLEAR: state_d = expire_d ? START : WAVE_CLEAR;
      GAME_OVER:  state_d = expire_d ? ATTRACT : GAME_OVER;
      default:    state_d = ATTRACT;
    endcase
    timer_load_d = state_d == START      ? 16'(START_FRAMES) :
                   state_d == DYING      ? 16'(DEATH_FRAMES) :
                   state_d == WAVE_CLEAR ? 16'(CLEAR_FRAMES) :
                   state_d == GAME_OVER  ? 16'(OVER_FRAMES)  : 16'd0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ATTRACT;
      timer_q     <= '0;
      blink_cnt_q <= '0;
      btn_q       <= 1'b0;
      hud_q       <= 1'b0;
      play_q      <= 1'b0;
      fr_q        <= 1'b0;
      kv_q        <= 1'b0;
      lc_q        <= 1'b0;
      kill_row_q  <= '0;
      kill_col_q  <= '0;
      lives_q     <= 2'(INIT_LIVES);
      score_q     <= '0;
      wave_q      <= '0;
    end else begin
      state_q <= state_d;
      btn_q   <= bus.btn_start;
      play_q  <= state_d == PLAYING;
      fr_q    <= 1'b0;
      kv_q    <= 1'b0;
      lc_q    <= 1'b0;
      // Any phase change restarts the frame timer and the blink phase
      if (state_d != state_q) begin
        timer_q     <= timer_load_d;
        blink_cnt_q <= '0;
        hud_q       <= 1'b0;
      end else begin
        if (bus.frame_tick && timer_q != 16'd0) timer_q <= timer_q - 16'd1;
        if (bus.frame_tick && blinking_d) begin
          blink_cnt_q <= blink_cnt_q + 4'd1;
          if (blink_cnt_q == 4'd15) hud_q <= ~hud_q;
        end
      end
      if (state_q == ATTRACT && btn_rise_d) begin
        score_q <= '0;
        lives_q <= 2'(INIT_LIVES);
        wave_q  <= '0;
        fr_q    <= 1'b1;
        lc_q    <= 1'b1;
      end
      if (state_q == PLAYING) begin
        if (hit_ok_d) begin
          kv_q       <= 1'b1;
          kill_row_q <= bus.hit_row;
          kill_col_q <= bus.hit_col;
          score_q    <= score_hit_d;
          lc_q       <= 1'b1;
        end
        if (bus.aliens_landed) lives_q <= 2'd0;
        else if (bus.cannon_hit) lives_q <= lives_dec_d;
        if (state_d != PLAYING) lc_q <= 1'b1;
      end
      if (state_q == WAVE_CLEAR && expire_d) begin
        wave_q <= wave_inc_d;
        fr_q   <= 1'b1;
      end
    end
  end
  assign bus.state           = state_q;
  assign bus.play_enable     = play_q;
  assign bus.formation_reset = fr_q;
  assign bus.kill_valid      = kv_q;
  assign bus.kill_row        = kill_row_q;
  assign bus.kill_col        = kill_col_q;
  assign bus.laser_clear     = lc_q;
  assign bus.lives           = lives_q;
  assign bus.score           = score_q;
  assign bus.wave            = wave_q;
  assign bus.hud_blink       = hud_q;
endmodule
